// File: rtl/ats21_cmd_sched.sv
// ATS21 command scheduler: two 2-entry client FIFOs feeding a HI/LO/WAIT issue FSM.
// Both lanes issue together, and completion or timeout retires every latched lane at once.

module ats21_cmd_fifo (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_push,
    input  logic [31:0] i_data,
    input  logic        i_pop,
    output logic        o_full,
    output logic        o_empty,
    output logic [31:0] o_head
);

    logic [31:0] r_mem [0:1];
    logic        r_wr;
    logic        r_rd;
    logic [1:0]  r_cnt;
    logic        w_push;
    logic        w_pop;

    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);
    assign o_head  = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push)
                r_wr <= ~r_wr;
            if (w_pop)
                r_rd <= ~r_rd;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage carries no reset; the occupancy count alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= i_data;
    end

endmodule

module ats21_cmd_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [31:0] a_instr,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [31:0] b_instr,
    output logic        b_ready,
    output logic        req,
    output logic [15:0] ctrlA,
    output logic [15:0] ctrlB,
    input  logic        ready,
    input  logic [1:0]  stat,
    output logic        a_done,
    output logic        b_done,
    output logic [1:0]  a_stat,
    output logic [1:0]  b_stat,
    output logic        timeout,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HI   = 2'd1;
    localparam logic [1:0] S_LO   = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [1:0]  r_state;
    logic        r_lane_a;
    logic        r_lane_b;
    logic [7:0]  r_cnt;
    logic        r_a_done;
    logic        r_b_done;
    logic [1:0]  r_a_stat;
    logic [1:0]  r_b_stat;

    logic        w_a_full;
    logic        w_a_empty;
    logic [31:0] w_a_head;
    logic        w_b_full;
    logic        w_b_empty;
    logic [31:0] w_b_head;
    logic        w_rsp;
    logic        w_tmo;
    logic        w_fin;

    assign a_ready = !w_a_full;
    assign b_ready = !w_b_full;

    // Heads stay put until the WAIT exit pops them, so HI and LO read the same word.
    assign w_rsp = (r_state == S_WAIT) && ready;
    assign w_tmo = (r_state == S_WAIT) && !ready && (r_cnt == 8'hFF);
    assign w_fin = w_rsp || w_tmo;

    ats21_cmd_fifo u_fifo_a (
        .clk     (clk),
        .reset   (reset),
        .i_push  (a_valid && a_ready),
        .i_data  (a_instr),
        .i_pop   (w_fin && r_lane_a),
        .o_full  (w_a_full),
        .o_empty (w_a_empty),
        .o_head  (w_a_head)
    );

    ats21_cmd_fifo u_fifo_b (
        .clk     (clk),
        .reset   (reset),
        .i_push  (b_valid && b_ready),
        .i_data  (b_instr),
        .i_pop   (w_fin && r_lane_b),
        .o_full  (w_b_full),
        .o_empty (w_b_empty),
        .o_head  (w_b_head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_lane_a <= 1'b0;
            r_lane_b <= 1'b0;
            r_cnt    <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_a_empty || !w_b_empty) begin
                        r_state  <= S_HI;
                        r_lane_a <= !w_a_empty;
                        r_lane_b <= !w_b_empty;
                    end
                end
                S_HI: r_state <= S_LO;
                S_LO: begin
                    r_state <= S_WAIT;
                    r_cnt   <= 8'd0;
                end
                default: begin
                    if (w_fin)
                        r_state <= S_IDLE;
                    else
                        r_cnt <= r_cnt + 8'd1;
                end
            endcase
        end
    end

    // Status only moves on a real acknowledge; a timeout leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            r_a_stat <= 2'b00;
            r_b_stat <= 2'b00;
        end else begin
            r_a_done <= w_rsp && r_lane_a;
            r_b_done <= w_rsp && r_lane_b;
            if (w_rsp && r_lane_a)
                r_a_stat <= stat;
            if (w_rsp && r_lane_b)
                r_b_stat <= stat;
        end
    end

    always_comb begin
        req   = 1'b0;
        ctrlA = 16'h0000;
        ctrlB = 16'h0000;
        case (r_state)
            S_HI: begin
                req   = 1'b1;
                ctrlA = r_lane_a ? w_a_head[31:16] : 16'h0000;
                ctrlB = r_lane_b ? w_b_head[31:16] : 16'h0000;
            end
            S_LO: begin
                ctrlA = r_lane_a ? w_a_head[15:0] : 16'h0000;
                ctrlB = r_lane_b ? w_b_head[15:0] : 16'h0000;
            end
            default: ;
        endcase
    end

    assign a_done  = r_a_done;
    assign b_done  = r_b_done;
    assign a_stat  = r_a_stat;
    assign b_stat  = r_b_stat;
    assign timeout = w_tmo;
    assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_ats21_cmd_sched.sv
// Directed bench for ats21_cmd_sched: single transfer, dual lane, full FIFO,
// timeout, mid-transaction reset and ready ignored outside WAIT.

module tb_ats21_cmd_sched;

    logic        clk;
    logic        reset;
    logic        a_valid;
    logic [31:0] a_instr;
    logic        a_ready;
    logic        b_valid;
    logic [31:0] b_instr;
    logic        b_ready;
    logic        req;
    logic [15:0] ctrlA;
    logic [15:0] ctrlB;
    logic        ready;
    logic [1:0]  stat;
    logic        a_done;
    logic        b_done;
    logic [1:0]  a_stat;
    logic [1:0]  b_stat;
    logic        timeout;
    logic        busy;

    int n_chk;
    int n_err;

    ats21_cmd_sched dut (
        .clk     (clk),
        .reset   (reset),
        .a_valid (a_valid),
        .a_instr (a_instr),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_instr (b_instr),
        .b_ready (b_ready),
        .req     (req),
        .ctrlA   (ctrlA),
        .ctrlB   (ctrlB),
        .ready   (ready),
        .stat    (stat),
        .a_done  (a_done),
        .b_done  (b_done),
        .a_stat  (a_stat),
        .b_stat  (b_stat),
        .timeout (timeout),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rst_vals(input string tag);
        check_val({tag, "_req"}, {31'd0, req}, 32'd0);
        check_val({tag, "_ctrlA"}, {16'd0, ctrlA}, 32'd0);
        check_val({tag, "_ctrlB"}, {16'd0, ctrlB}, 32'd0);
        check_val({tag, "_done"}, {30'd0, a_done, b_done}, 32'd0);
        check_val({tag, "_stat"}, {28'd0, a_stat, b_stat}, 32'd0);
        check_val({tag, "_tmo"}, {31'd0, timeout}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_rdy"}, {30'd0, a_ready, b_ready}, 32'd3);
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        reset   = 1'b0;
        a_valid = 1'b0;
        a_instr = 32'd0;
        b_valid = 1'b0;
        b_instr = 32'd0;
        ready   = 1'b0;
        stat    = 2'b00;
        repeat (2) tick();
        check_rst_vals("por");
        reset = 1'b1;

        // single A transfer, ack in first WAIT cycle
        a_valid = 1'b1;
        a_instr = 32'h2202_0000;
        tick();
        a_valid = 1'b0;
        check_val("t1_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        check_val("t1_hi_req", {31'd0, req}, 32'd1);
        check_val("t1_hi_ctrlA", {16'd0, ctrlA}, 32'h2202);
        check_val("t1_hi_ctrlB", {16'd0, ctrlB}, 32'h0);
        tick();
        check_val("t1_lo_req", {31'd0, req}, 32'd0);
        check_val("t1_lo_ctrlA", {16'd0, ctrlA}, 32'h0);
        tick();
        check_val("t1_wait_busy", {31'd0, busy}, 32'd1);
        check_val("t1_wait_done", {31'd0, a_done}, 32'd0);
        ready = 1'b1;
        stat  = 2'b01;
        tick();
        ready = 1'b0;
        stat  = 2'b00;
        check_val("t1_a_done", {31'd0, a_done}, 32'd1);
        check_val("t1_a_stat", {30'd0, a_stat}, 32'd1);
        check_val("t1_b_done", {31'd0, b_done}, 32'd0);
        check_val("t1_busy_end", {31'd0, busy}, 32'd0);
        tick();
        check_val("t1_done_pulse", {31'd0, a_done}, 32'd0);

        // both lanes in one transaction
        a_valid = 1'b1;
        a_instr = 32'hA000_0045;
        b_valid = 1'b1;
        b_instr = 32'hA100_0045;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        check_val("t2_hi", {ctrlA, ctrlB}, 32'hA000_A100);
        tick();
        check_val("t2_lo", {ctrlA, ctrlB}, 32'h0045_0045);
        tick();
        ready = 1'b1;
        stat  = 2'b10;
        tick();
        ready = 1'b0;
        check_val("t2_done", {30'd0, a_done, b_done}, 32'd3);
        check_val("t2_stat", {28'd0, a_stat, b_stat}, 32'hA);

        // three pushes into a 2-entry FIFO
        a_valid = 1'b1;
        a_instr = 32'h1111_0001;
        tick();
        check_val("t3_rdy1", {31'd0, a_ready}, 32'd1);
        a_instr = 32'h2222_0002;
        tick();
        check_val("t3_full", {31'd0, a_ready}, 32'd0);
        check_val("t3_hi1", {15'd0, req, ctrlA}, 32'h1_1111);
        a_instr = 32'h3333_0003;
        tick();
        a_valid = 1'b0;
        check_val("t3_lo1", {16'd0, ctrlA}, 32'h0001);
        tick();
        tick();
        tick();
        check_val("t3_hold_busy", {31'd0, busy}, 32'd1);
        check_val("t3_hold_req", {31'd0, req}, 32'd0);
        ready = 1'b1;
        stat  = 2'b11;
        tick();
        ready = 1'b0;
        check_val("t3_done1", {31'd0, a_done}, 32'd1);
        check_val("t3_gap_req", {31'd0, req}, 32'd0);
        tick();
        check_val("t3_hi2", {15'd0, req, ctrlA}, 32'h1_2222);
        tick();
        check_val("t3_lo2", {16'd0, ctrlA}, 32'h0002);
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check_val("t3_done2", {31'd0, a_done}, 32'd1);
        tick();
        tick();
        check_val("t3_dropped", {30'd0, busy, a_ready}, 32'd1);

        // timeout after 256 WAIT cycles, then the next word issues
        a_valid = 1'b1;
        a_instr = 32'h3333_0003;
        tick();
        a_instr = 32'h4444_0004;
        tick();
        a_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 254; i++) tick();
        check_val("t4_pre_tmo", {31'd0, timeout}, 32'd0);
        tick();
        check_val("t4_tmo", {30'd0, timeout, busy}, 32'd3);
        tick();
        check_val("t4_tmo_end", {31'd0, timeout}, 32'd0);
        check_val("t4_no_done", {31'd0, a_done}, 32'd0);
        check_val("t4_stat_kept", {30'd0, a_stat}, 32'd3);
        tick();
        check_val("t4_next_hi", {15'd0, req, ctrlA}, 32'h1_4444);
        tick();
        tick();
        ready = 1'b1;
        stat  = 2'b10;
        tick();
        ready = 1'b0;
        stat  = 2'b00;
        check_val("t4_done", {29'd0, a_done, a_stat}, 32'h6);

        // reset asserted during LO with two words queued
        a_valid = 1'b1;
        a_instr = 32'h5555_0005;
        tick();
        a_instr = 32'h6666_0006;
        tick();
        a_valid = 1'b0;
        tick();
        check_val("t5_in_lo", {16'd0, ctrlA}, 32'h0005);
        reset = 1'b0;
        #1;
        check_rst_vals("t5_async");
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("t5_post", {29'd0, busy, a_done, timeout}, 32'd0);
        end

        // ready ignored in IDLE, HI and LO
        b_valid = 1'b1;
        b_instr = 32'h5A5A_0007;
        ready   = 1'b1;
        stat    = 2'b11;
        tick();
        b_valid = 1'b0;
        check_val("t6_idle_done", {31'd0, b_done}, 32'd0);
        tick();
        check_val("t6_hi", {15'd0, req, ctrlB}, 32'h1_5A5A);
        tick();
        ready = 1'b0;
        check_val("t6_lo", {15'd0, b_done, ctrlB}, 32'h0_0007);
        tick();
        check_val("t6_wait", {30'd0, busy, b_done}, 32'd2);
        tick();
        check_val("t6_wait2", {30'd0, busy, b_done}, 32'd2);
        ready = 1'b1;
        stat  = 2'b01;
        tick();
        ready = 1'b0;
        check_val("t6_done", {28'd0, a_done, b_done, b_stat}, 32'h5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
